// File: rtl/boot_loader_pkg.sv
// Shared CPU constants for the boot loader: opcode field position, the
// halt opcode that ends a program image, and the loader state encodings.
package boot_loader_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;

    // Opcode field position inside an instruction word.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    // Opcode definitions.
    localparam logic [5:0] HALT_OPCODE = 6'b011000;

    // Loader FSM state encodings.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // Extract the opcode field from an instruction word.
    function automatic logic [5:0] opcode_of(input logic [DATA_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Disk read port and instruction-memory write port used by the boot loader.
// The master side is the loader itself; the slave side is disk plus memory.
interface boot_loader_if;
    import boot_loader_pkg::*;

    logic              disk_rd;
    logic [ADDR_W-1:0] disk_addr;
    logic [DATA_W-1:0] disk_data;
    logic              disk_valid;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;

    modport master (
        output disk_rd, disk_addr, im_we, im_addr, im_wdata,
        input  disk_data, disk_valid
    );

    modport slave (
        input  disk_rd, disk_addr, im_we, im_addr, im_wdata,
        output disk_data, disk_valid
    );

endinterface

// File: rtl/boot_loader.sv
// Boot loader: copies a program image word by word from disk into
// instruction memory, stopping on the halt opcode or at MAX_WORDS.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [5:0]  HALT_OP   = HALT_OPCODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    boot_loader_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    localparam logic [ADDR_W-1:0] MAX_COUNT = ADDR_W'(MAX_WORDS);

    state_t            state_q;
    logic              disk_rd_q;
    logic [ADDR_W-1:0] disk_addr_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [DATA_W-1:0] im_wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [ADDR_W-1:0] word_count_q;

    // Count after the word currently being written is accounted for.
    logic [ADDR_W-1:0] word_count_d;
    assign word_count_d = word_count_q + ADDR_W'(1);

    // Loader FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            disk_rd_q    <= 1'b0;
            disk_addr_q  <= '0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_q      <= ST_READ;
                        disk_addr_q  <= base_addr;
                        word_count_q <= '0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        disk_rd_q    <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_READ: begin
                    // Request stays up with a stable address until the disk answers.
                    if (bus.disk_valid) begin
                        state_q    <= ST_WRITE;
                        disk_rd_q  <= 1'b0;
                        im_wdata_q <= bus.disk_data;
                        im_addr_q  <= word_count_q;
                        im_we_q    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // The word being written always counts, halt word included.
                    im_we_q      <= 1'b0;
                    word_count_q <= word_count_d;
                    if (opcode_of(im_wdata_q) == HALT_OP) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (word_count_d == MAX_COUNT) begin
                        state_q <= ST_ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        state_q     <= ST_READ;
                        disk_addr_q <= disk_addr_q + ADDR_W'(1);
                        disk_rd_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    disk_rd_q <= 1'b0;
                    im_we_q   <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.disk_rd   = disk_rd_q;
    assign bus.disk_addr = disk_addr_q;
    assign bus.im_we     = im_we_q;
    assign bus.im_addr   = im_addr_q;
    assign bus.im_wdata  = im_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: stimulus pushes expected instruction
// memory writes, a monitor pops and compares them on every im_we pulse.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start;
    logic [25:0] base_addr;
    logic        busy;
    logic        done;
    logic        error;
    logic [25:0] word_count;

    boot_loader_if bus();

    boot_loader #(
        .MAX_WORDS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] disk_mem[int];
    int          latency;
    bit          disk_en;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] disk_word(input logic [25:0] a);
        if (disk_mem.exists(int'(a))) return disk_mem[int'(a)];
        return 32'h0000_0000;
    endfunction

    task automatic push_wr(input logic [25:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic start_load(input logic [25:0] base);
        @(negedge clk);
        base_addr = base;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(output int cycles);
        cycles = 0;
        while (!(done || error) && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disk_rd"},    {31'd0, bus.disk_rd},   32'd0);
        check({tag, "_im_we"},      {31'd0, bus.im_we},     32'd0);
        check({tag, "_busy"},       {31'd0, busy},          32'd0);
        check({tag, "_done"},       {31'd0, done},          32'd0);
        check({tag, "_error"},      {31'd0, error},         32'd0);
        check({tag, "_word_count"}, {6'd0, word_count},     32'd0);
        check({tag, "_disk_addr"},  {6'd0, bus.disk_addr},  32'd0);
        check({tag, "_im_addr"},    {6'd0, bus.im_addr},    32'd0);
        check({tag, "_im_wdata"},   bus.im_wdata,           32'd0);
    endtask

    // Disk model: answers a pending read after 'latency' waiting cycles.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (disk_en) begin
                if (rst || !bus.disk_rd) begin
                    bus.disk_valid = 1'b0;
                    wait_cnt       = 0;
                end else if (wait_cnt >= latency) begin
                    bus.disk_valid = 1'b1;
                    bus.disk_data  = disk_word(bus.disk_addr);
                    wait_cnt       = 0;
                end else begin
                    bus.disk_valid = 1'b0;
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: compares each write pulse against the scoreboard and checks
    // that a pending read keeps its address.
    initial begin
        wr_t         e;
        logic        prev_rd;
        logic [25:0] prev_addr;
        prev_rd   = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (bus.im_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             bus.im_addr, bus.im_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("im_addr", {6'd0, bus.im_addr}, {6'd0, e.addr});
                    check("im_wdata", bus.im_wdata, e.data);
                end
            end
            if (!rst && bus.disk_rd && prev_rd)
                check("disk_addr_stable", {6'd0, bus.disk_addr}, {6'd0, prev_addr});
            prev_rd   = bus.disk_rd && !rst;
            prev_addr = bus.disk_addr;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cycles;
        bus.disk_valid = 1'b0;
        bus.disk_data  = '0;
        start          = 1'b0;
        base_addr      = '0;
        latency        = 0;
        disk_en        = 1'b1;

        disk_mem[100]        = 32'h2001_0005;  // addi
        disk_mem[101]        = 32'hAC01_0000;  // sw
        disk_mem[102]        = 32'h6000_0000;  // halt
        disk_mem[200]        = 32'h6000_0000;
        disk_mem[300]        = 32'h1234_5678;
        disk_mem[301]        = 32'h6000_0001;
        disk_mem[400]        = 32'h2000_0001;
        disk_mem[401]        = 32'h2000_0002;
        disk_mem[402]        = 32'h0000_0003;
        disk_mem[403]        = 32'hAC00_0004;
        disk_mem[404]        = 32'h6000_0000;
        disk_mem[26'h3FFFFFF] = 32'h2000_0007;
        disk_mem[0]          = 32'h6000_0000;

        // Reset state.
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Normal load, disk answers in the first READ cycle.
        push_wr(26'd0, 32'h2001_0005);
        push_wr(26'd1, 32'hAC01_0000);
        push_wr(26'd2, 32'h6000_0000);
        start_load(26'd100);
        check("norm_busy", {31'd0, busy}, 32'd1);
        check("norm_disk_rd", {31'd0, bus.disk_rd}, 32'd1);
        check("norm_disk_addr", {6'd0, bus.disk_addr}, 32'd100);
        wait_end(cycles);
        check("norm_cycles", cycles, 32'd6);
        check("norm_done", {31'd0, done}, 32'd1);
        check("norm_error", {31'd0, error}, 32'd0);
        check("norm_count", {6'd0, word_count}, 32'd3);
        check("norm_busy_end", {31'd0, busy}, 32'd0);
        check("norm_sb_empty", exp_q.size(), 32'd0);

        // Slow disk: 5 waiting cycles per read.
        latency = 5;
        push_wr(26'd0, 32'h1234_5678);
        push_wr(26'd1, 32'h6000_0001);
        start_load(26'd300);
        wait_end(cycles);
        check("slow_cycles", cycles, 32'd14);
        check("slow_done", {31'd0, done}, 32'd1);
        check("slow_count", {6'd0, word_count}, 32'd2);
        check("slow_sb_empty", exp_q.size(), 32'd0);

        // Start during READ is ignored.
        latency = 3;
        push_wr(26'd0, 32'h2001_0005);
        push_wr(26'd1, 32'hAC01_0000);
        push_wr(26'd2, 32'h6000_0000);
        start_load(26'd100);
        start_load(26'd500);
        check("ign_disk_addr", {6'd0, bus.disk_addr}, 32'd100);
        check("ign_busy", {31'd0, busy}, 32'd1);
        wait_end(cycles);
        check("ign_done", {31'd0, done}, 32'd1);
        check("ign_count", {6'd0, word_count}, 32'd3);
        check("ign_sb_empty", exp_q.size(), 32'd0);

        // Restart from DONE at a new base.
        latency = 0;
        push_wr(26'd0, 32'h6000_0000);
        start_load(26'd200);
        check("rst200_done", {31'd0, done}, 32'd0);
        check("rst200_count", {6'd0, word_count}, 32'd0);
        check("rst200_disk_addr", {6'd0, bus.disk_addr}, 32'd200);
        wait_end(cycles);
        check("rst200_done_end", {31'd0, done}, 32'd1);
        check("rst200_count_end", {6'd0, word_count}, 32'd1);

        // Overflow: four non-halt words with MAX_WORDS=4.
        push_wr(26'd0, 32'h2000_0001);
        push_wr(26'd1, 32'h2000_0002);
        push_wr(26'd2, 32'h0000_0003);
        push_wr(26'd3, 32'hAC00_0004);
        start_load(26'd400);
        wait_end(cycles);
        check("ovf_cycles", cycles, 32'd8);
        check("ovf_error", {31'd0, error}, 32'd1);
        check("ovf_done", {31'd0, done}, 32'd0);
        check("ovf_count", {6'd0, word_count}, 32'd4);
        check("ovf_busy", {31'd0, busy}, 32'd0);
        check("ovf_disk_addr", {6'd0, bus.disk_addr}, 32'd403);
        check("ovf_sb_empty", exp_q.size(), 32'd0);

        // Disk address wraps at 2^26.
        push_wr(26'd0, 32'h2000_0007);
        push_wr(26'd1, 32'h6000_0000);
        start_load(26'h3FF_FFFF);
        wait_end(cycles);
        check("wrap_done", {31'd0, done}, 32'd1);
        check("wrap_error", {31'd0, error}, 32'd0);
        check("wrap_disk_addr", {6'd0, bus.disk_addr}, 32'd0);
        check("wrap_count", {6'd0, word_count}, 32'd2);
        check("wrap_sb_empty", exp_q.size(), 32'd0);

        // Reset during the second READ, then a late disk_valid.
        latency = 4;
        push_wr(26'd0, 32'h2001_0005);
        start_load(26'd100);
        cycles = 0;
        while (!bus.im_we && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("mid_first_write", {31'd0, bus.im_we}, 32'd1);
        @(posedge clk);
        #1;
        check("mid_disk_rd", {31'd0, bus.disk_rd}, 32'd1);
        check("mid_disk_addr", {6'd0, bus.disk_addr}, 32'd101);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        disk_en = 1'b0;
        @(negedge clk);
        bus.disk_valid = 1'b1;
        bus.disk_data  = 32'h6000_0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("late_im_we", {31'd0, bus.im_we}, 32'd0);
            check("late_busy", {31'd0, busy}, 32'd0);
        end
        bus.disk_valid = 1'b0;
        disk_en        = 1'b1;
        check("late_sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
